// File: rtl/bounce_sprite_gen.sv
// Raster-scanned pixel source: animated box over a background colour, black in blanking.
// The box steps horizontally once per frame at the raster wrap and bounces off the active edges.
module bounce_sprite_gen #(
  parameter int          H_TOTAL  = 800,
  parameter int          V_TOTAL  = 525,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          BOX_W    = 80,
  parameter int          BOX_H    = 80,
  parameter int          BOX_Y    = 200,
  parameter int          STEP     = 5,
  parameter logic [11:0] FG       = 12'h00F,
  parameter logic [11:0] BG       = 12'hF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        pause,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic [11:0] rgb
);

  localparam logic [10:0] L_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] L_V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] L_BOX_W  = 11'(BOX_W);
  localparam logic [10:0] L_BOX_Y0 = 11'(BOX_Y);
  localparam logic [10:0] L_BOX_Y1 = 11'(BOX_Y + BOX_H);
  localparam logic [10:0] L_STEP   = 11'(STEP);
  localparam logic [10:0] L_POSMAX = 11'(H_ACTIVE - BOX_W);

  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

  logic [9:0]  r_x, r_y, r_pos;
  logic        r_fs;
  logic [11:0] r_rgb;
  dir_t        r_dir;

  logic        w_x_last, w_y_last;
  logic [10:0] w_x11, w_y11, w_pos11, w_pos_sum;
  logic        w_active, w_hit;
  logic [11:0] w_colour;
  dir_t        w_dir_nxt;
  logic [9:0]  w_pos_nxt;

  assign w_x_last = (r_x == 10'(H_TOTAL - 1));
  assign w_y_last = (r_y == 10'(V_TOTAL - 1));

  // Pixel colour for the current raster position; all compares widened to 11 bits
  assign w_x11     = {1'b0, r_x};
  assign w_y11     = {1'b0, r_y};
  assign w_pos11   = {1'b0, r_pos};
  assign w_pos_sum = w_pos11 + L_STEP;
  assign w_active  = (w_x11 < L_H_ACT) && (w_y11 < L_V_ACT);
  assign w_hit     = (w_x11 >= w_pos11) && (w_x11 < w_pos11 + L_BOX_W) &&
                     (w_y11 >= L_BOX_Y0) && (w_y11 < L_BOX_Y1);
  assign w_colour  = !w_active ? 12'h000 : (w_hit ? FG : BG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else if (pix_en) begin
      r_rgb <= w_colour;
      r_fs  <= w_x_last && w_y_last;
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end else begin
      r_fs <= 1'b0;
    end
  end

  // Motion FSM: moves clamp at both edges and reverse direction there
  always_comb begin
    w_dir_nxt = r_dir;
    w_pos_nxt = r_pos;
    if (r_fs && !pause) begin
      case (r_dir)
        DIR_RIGHT: begin
          if (w_pos_sum >= L_POSMAX) begin
            w_pos_nxt = L_POSMAX[9:0];
            w_dir_nxt = DIR_LEFT;
          end else begin
            w_pos_nxt = w_pos_sum[9:0];
          end
        end
        DIR_LEFT: begin
          if (w_pos11 <= L_STEP) begin
            w_pos_nxt = '0;
            w_dir_nxt = DIR_RIGHT;
          end else begin
            w_pos_nxt = r_pos - L_STEP[9:0];
          end
        end
        default: begin
          w_pos_nxt = '0;
          w_dir_nxt = DIR_RIGHT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= DIR_RIGHT;
    end else begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign rgb         = r_rgb;

endmodule

// File: tb/tb_bounce_sprite_gen.sv
// Randomized bench for bounce_sprite_gen on a shrunken raster, checked every cycle
// against a behavioural model of raster position, box trajectory and pixel colour.
module tb_bounce_sprite_gen;

  localparam int HT = 40, VT = 12, HA = 32, VA = 8;
  localparam int BW = 8, BH = 3, BY = 2, ST = 5;
  localparam logic [11:0] FGC = 12'h00F, BGC = 12'hF00;
  localparam int PMAX = HA - BW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  x, y;
  logic        frame_start;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;

  // Model state
  int mx, my, mpos, mrgb, mfs;
  bit mleft;
  int frames_seen;
  int pos_hi, pos_lo;

  bounce_sprite_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .BOX_W(BW), .BOX_H(BH), .BOX_Y(BY), .STEP(ST), .FG(FGC), .BG(BGC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pause(pause),
    .x(x), .y(y), .frame_start(frame_start), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int colour(input int px, input int py, input int bpos);
    if (px >= HA || py >= VA) return 0;
    if (px >= bpos && px < bpos + BW && py >= BY && py < BY + BH) return int'(FGC);
    return int'(BGC);
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mpos = 0; mleft = 1'b0; mrgb = 0; mfs = 0;
  endtask

  task automatic model_step(input bit pe, input bit pa);
    int old_pos = mpos;
    int nfs = 0;
    if (mfs != 0 && !pa) begin
      frames_seen++;
      if (!mleft) begin
        mpos = (old_pos + ST > PMAX) ? PMAX : old_pos + ST;
        if (mpos == PMAX) mleft = 1'b1;
      end else begin
        mpos = (old_pos - ST < 0) ? 0 : old_pos - ST;
        if (mpos == 0) mleft = 1'b0;
      end
      if (mpos > pos_hi) pos_hi = mpos;
      if (mpos < pos_lo) pos_lo = mpos;
    end
    if (pe) begin
      mrgb = colour(mx, my, old_pos);
      nfs = (mx == HT - 1 && my == VT - 1) ? 1 : 0;
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    mfs = nfs;
  endtask

  task automatic compare_all();
    check("x", int'(x), mx);
    check("y", int'(y), my);
    check("frame_start", int'(frame_start), mfs);
    check("rgb", int'(rgb), mrgb);
  endtask

  task automatic cycle(input bit pe, input bit pa);
    pix_en = pe;
    pause  = pa;
    @(posedge clk);
    model_step(pe, pa);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_rgb", int'(rgb), 0);
    check("rst_fs", int'(frame_start), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bit pa_hold;
    frames_seen = 0;
    pos_hi = 0;
    pos_lo = 0;
    model_reset();
    #1;
    check("rst0_x", int'(x), 0);
    check("rst0_y", int'(y), 0);
    check("rst0_rgb", int'(rgb), 0);
    check("rst0_fs", int'(frame_start), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Continuous strobe: covers both bounce clamps with STEP not dividing travel
    for (int i = 0; i < 12 * HT * VT; i++) cycle(1'b1, 1'b0);
    check("pos_reached_max", pos_hi, PMAX);
    check("pos_reached_min", pos_lo, 0);

    // Pause held across several frame starts
    for (int i = 0; i < 3 * HT * VT; i++) cycle(1'b1, 1'b1);

    // Randomized strobe and pause, pause kept per frame with occasional mid-frame flips
    pa_hold = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      if (frame_start) pa_hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) pa_hold = ~pa_hold;
      cycle($urandom_range(0, 3) != 0, pa_hold);
    end

    // Strobe idle: everything must hold
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // Mid-frame asynchronous reset, then resume
    async_reset();
    for (int i = 0; i < 3 * HT * VT; i++) cycle($urandom_range(0, 1) == 1, 1'b0);

    check("frames_moved_nonzero", int'(frames_seen > 10), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
